isqrt_sum_fsm: RTL and testbench

Parametrised FSM that computes the sum of integer square roots of N_ARGS unsigned arguments, res = Σ isqrt(arg[i]), using N_ISQRT external isqrt units in parallel. It generalises the three-argument formula FSM to any argument count and unit count. Arguments are dispatched in batches of up to N_ISQRT, and per-lane results are accumulated as they arrive. It sits between an argument producer with a valid/ready handshake and a bank of pipelined isqrt units that share its clock and reset.

---
 rtl/isqrt_sum_fsm.sv | 137 +++++++++++++
 tb/tb_isqrt_sum_fsm.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/isqrt_sum_fsm.sv
// isqrt_sum_fsm: sums the integer square roots of N_ARGS arguments by dispatching
// them in batches of up to N_ISQRT to a bank of external pipelined isqrt units and
// accumulating the per-lane results as they come back.
module isqrt_sum_fsm #(
    parameter int unsigned N_ARGS  = 3,
    parameter int unsigned N_ISQRT = 2,
    parameter int unsigned X_W     = 32,
    parameter int unsigned Y_W     = 16,
    parameter int unsigned RES_W   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arg_vld,
    output logic                     arg_rdy,
    input  logic [N_ARGS*X_W-1:0]    args,
    output logic                     res_vld,
    output logic [RES_W-1:0]         res,
    output logic [N_ISQRT-1:0]       isqrt_x_vld,
    output logic [N_ISQRT*X_W-1:0]   isqrt_x,
    input  logic [N_ISQRT-1:0]       isqrt_y_vld,
    input  logic [N_ISQRT*Y_W-1:0]   isqrt_y
);

    localparam int unsigned NB   = (N_ARGS + N_ISQRT - 1) / N_ISQRT;
    localparam int unsigned BW   = (NB > 1) ? $clog2(NB) : 1;
    // Argument store is padded to a whole number of batches so every lane of the
    // last batch indexes inside the vector.
    localparam int unsigned PW   = NB * N_ISQRT * X_W;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StWait,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [PW-1:0]      args_q, args_d;
    logic [RES_W-1:0]   acc_q, acc_d;
    logic [RES_W-1:0]   res_q, res_d;
    logic [BW-1:0]      batch_q, batch_d;
    logic [N_ISQRT-1:0] done_q, done_d;
    logic [N_ISQRT-1:0] active;
    logic [N_ISQRT-1:0] fire;

    // Lanes that carry an argument in the current batch.
    always_comb begin
        active = '0;
        for (int unsigned j = 0; j < N_ISQRT; j++) begin
            active[j] = ((32'(batch_q) * N_ISQRT + j) < N_ARGS);
        end
    end

    // Next-state logic, accumulation and request outputs.
    always_comb begin
        state_d     = state_q;
        args_d      = args_q;
        acc_d       = acc_q;
        res_d       = res_q;
        batch_d     = batch_q;
        done_d      = done_q;
        fire        = '0;
        isqrt_x_vld = '0;
        isqrt_x     = '0;
        unique case (state_q)
            StIdle: begin
                if (arg_vld) begin
                    args_d  = PW'(args);
                    acc_d   = '0;
                    batch_d = '0;
                    state_d = StSend;
                end
            end
            StSend: begin
                isqrt_x_vld = active;
                for (int unsigned j = 0; j < N_ISQRT; j++) begin
                    if (active[j]) begin
                        isqrt_x[j*X_W +: X_W] =
                            args_q[(32'(batch_q) * N_ISQRT + j) * X_W +: X_W];
                    end
                end
                done_d  = '0;
                state_d = StWait;
            end
            StWait: begin
                // Only first report of an active lane counts; repeats are dropped.
                fire = isqrt_y_vld & active & ~done_q;
                for (int unsigned j = 0; j < N_ISQRT; j++) begin
                    if (fire[j]) begin
                        acc_d = acc_d + RES_W'(isqrt_y[j*Y_W +: Y_W]);
                    end
                end
                done_d = done_q | fire;
                if ((done_d & active) == active) begin
                    if (batch_q == BW'(NB - 1)) begin
                        res_d   = acc_d;
                        state_d = StDone;
                    end else begin
                        batch_d = batch_q + 1'b1;
                        state_d = StSend;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            args_q  <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            batch_q <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            args_q  <= args_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            batch_q <= batch_d;
            done_q  <= done_d;
        end
    end

    // arg_rdy is held low while reset is asserted, not just once state settles.
    assign arg_rdy = (state_q == StIdle) && !rst;
    assign res_vld = (state_q == StDone);
    assign res     = res_q;

endmodule

// File: tb/tb_isqrt_sum_fsm.sv
// tb_isqrt_sum_fsm: drives two isqrt_sum_fsm instances (3 args / 2 lanes and
// 5 args / 2 lanes) against behavioural isqrt units and a plain-arithmetic model.
module tb_isqrt_sum_fsm;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance 0: defaults
    logic         vld0, rdy0, rv0;
    logic [95:0]  args0;
    logic [31:0]  res0;
    logic [1:0]   xv0, yv0;
    logic [63:0]  x0;
    logic [31:0]  y0;
    // Instance 1: five arguments
    logic         vld1, rdy1, rv1;
    logic [159:0] args1;
    logic [31:0]  res1;
    logic [1:0]   xv1, yv1;
    logic [63:0]  x1;
    logic [31:0]  y1;

    isqrt_sum_fsm dut0 (
        .clk(clk), .rst(rst), .arg_vld(vld0), .arg_rdy(rdy0), .args(args0),
        .res_vld(rv0), .res(res0), .isqrt_x_vld(xv0), .isqrt_x(x0),
        .isqrt_y_vld(yv0), .isqrt_y(y0)
    );

    isqrt_sum_fsm #(.N_ARGS(5), .N_ISQRT(2), .X_W(32), .Y_W(16), .RES_W(32)) dut1 (
        .clk(clk), .rst(rst), .arg_vld(vld1), .arg_rdy(rdy1), .args(args1),
        .res_vld(rv1), .res(res1), .isqrt_x_vld(xv1), .isqrt_x(x1),
        .isqrt_y_vld(yv1), .isqrt_y(y1)
    );

    function automatic logic [15:0] isqrt(input logic [31:0] v);
        longint r;
        r = longint'($floor($sqrt(real'(v))));
        while (r * r > longint'(v)) r--;
        while ((r + 1) * (r + 1) <= longint'(v)) r++;
        return r[15:0];
    endfunction

    // Behavioural isqrt units: per-lane latency, one result L cycles after request.
    int          lat0 [2];
    int          lat1 [2];
    logic [15:0] pv0 [2];
    logic [15:0] pv1 [2];
    logic [15:0] py0 [2][16];
    logic [15:0] py1 [2][16];
    logic [1:0]  ex0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < 2; j++) begin
                pv0[j] <= '0;
                pv1[j] <= '0;
                for (int k = 0; k < 16; k++) begin
                    py0[j][k] <= '0;
                    py1[j][k] <= '0;
                end
            end
        end else begin
            for (int j = 0; j < 2; j++) begin
                pv0[j] <= (pv0[j] >> 1) | (xv0[j] ? (16'd1 << (lat0[j] - 1)) : 16'd0);
                pv1[j] <= (pv1[j] >> 1) | (xv1[j] ? (16'd1 << (lat1[j] - 1)) : 16'd0);
                for (int k = 0; k < 15; k++) begin
                    py0[j][k] <= (xv0[j] && k == lat0[j] - 1) ? isqrt(x0[j*32 +: 32])
                                                               : py0[j][k+1];
                    py1[j][k] <= (xv1[j] && k == lat1[j] - 1) ? isqrt(x1[j*32 +: 32])
                                                               : py1[j][k+1];
                end
                py0[j][15] <= '0;
                py1[j][15] <= '0;
            end
        end
    end

    // ex0 injects extra strobes carrying a bogus value on instance 0.
    assign yv0 = {pv0[1][0], pv0[0][0]} | ex0;
    assign y0  = {ex0[1] ? 16'h1234 : py0[1][0], ex0[0] ? 16'h1234 : py0[0][0]};
    assign yv1 = {pv1[1][0], pv1[0][0]};
    assign y1  = {py1[1][0], py1[0][0]};

    int          passes = 0;
    int          total  = 0;
    logic [31:0] cur  [5];
    logic [31:0] cur2 [5];
    logic [31:0] last_res [2];
    bit          pulse;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic logic [31:0] ref_sum(input int d);
        logic [31:0] s = 0;
        for (int i = 0; i < (d ? 5 : 3); i++) s += 32'(isqrt(cur[i]));
        return s;
    endfunction

    // Expected cycle of res_vld: 1 + per batch (slowest active lane latency + 1).
    function automatic int exp_lat(input int d);
        int nargs = d ? 5 : 3;
        int t = 1;
        for (int b = 0; b * 2 < nargs; b++) begin
            int m = 0;
            for (int j = 0; j < 2; j++) begin
                int l = d ? lat1[j] : lat0[j];
                if (b * 2 + j < nargs && l > m) m = l;
            end
            t += m + 1;
        end
        return t;
    endfunction

    task automatic drive_args(input int d);
        for (int i = 0; i < 5; i++) begin
            if (d == 0 && i < 3) args0[i*32 +: 32] = cur[i];
            if (d == 1) args1[i*32 +: 32] = cur[i];
        end
    endtask

    task automatic rand_args();
        for (int i = 0; i < 5; i++) cur[i] = $urandom >> $urandom_range(0, 31);
    endtask

    task automatic start(input int d);
        @(negedge clk);
        drive_args(d);
        if (d == 0) vld0 = 1'b1;
        else        vld1 = 1'b1;
        chk("arg_rdy_idle", d ? rdy1 : rdy0, 1);
        @(posedge clk);
    endtask

    // Called just after the acceptance edge; follows the operation to its strobe.
    task automatic finish(input int d, input int elat, input bit keep, input logic [31:0] esum);
        int          n = 0;
        int          sends = 0;
        int          nargs = d ? 5 : 3;
        logic [31:0] ea [5];
        logic        r_v;
        logic [1:0]  xv;
        logic [63:0] xx;
        logic [31:0] rr;
        ea = cur;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (c == 1) begin
                if (keep) begin
                    cur = cur2;
                    drive_args(d);
                end else if (d == 0) vld0 = 1'b0;
                else vld1 = 1'b0;
            end
            ex0 = (pulse && d == 0) ? ((c == 6) ? 2'b01 : (c == 10) ? 2'b10 : 2'b00) : 2'b00;
            r_v = d ? rv1 : rv0;
            xv  = d ? xv1 : xv0;
            xx  = d ? x1 : x0;
            rr  = d ? res1 : res0;
            if (c == 2) chk("res_hold", rr, last_res[d]);
            if (xv != 2'b00) begin
                sends++;
                for (int j = 0; j < 2; j++) begin
                    int idx = (sends - 1) * 2 + j;
                    if (idx < nargs) begin
                        chk("x_vld_active", xv[j], 1);
                        chk("x_active", xx[j*32 +: 32], ea[idx]);
                    end else begin
                        chk("x_vld_inactive", xv[j], 0);
                        chk("x_inactive", xx[j*32 +: 32], 0);
                    end
                end
            end else begin
                chk("x_quiet", xx, 0);
            end
            if (r_v) begin
                n = c;
                break;
            end
        end
        ex0 = 2'b00;
        chk("latency", n, elat);
        chk("batches", sends, d ? 3 : 2);
        chk("res", rr, esum);
        last_res[d] = esum;
        if (!keep) begin
            @(negedge clk);
            chk("res_vld_one_cycle", d ? rv1 : rv0, 0);
            chk("arg_rdy_back", d ? rdy1 : rdy0, 1);
            chk("res_after", d ? res1 : res0, esum);
        end
    endtask

    initial begin
        vld0 = 0; vld1 = 0; args0 = '0; args1 = '0; ex0 = 0; pulse = 0;
        lat0 = '{4, 4};
        lat1 = '{3, 3};
        last_res = '{0, 0};
        #2;
        chk("rst_rdy0", rdy0, 0);
        chk("rst_rv0", rv0, 0);
        chk("rst_res0", res0, 0);
        chk("rst_xv0", xv0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("post_rst_rdy0", rdy0, 1);
        chk("post_rst_rdy1", rdy1, 1);
        chk("post_rst_res1", res1, 0);

        cur[0:2] = '{16, 25, 36};
        start(0);
        finish(0, 11, 0, 15);

        cur[0:2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        start(0);
        finish(0, 11, 0, 196605);

        cur[0:2] = '{0, 0, 0};
        start(0);
        finish(0, 11, 0, 0);

        cur = '{1, 4, 9, 16, 100};
        start(1);
        finish(1, 13, 0, 20);

        // Random vectors and random per-lane latencies on both instances
        for (int it = 0; it < 4; it++) begin
            lat0[0] = $urandom_range(1, 6);
            lat0[1] = $urandom_range(1, 6);
            rand_args();
            start(0);
            finish(0, exp_lat(0), 0, ref_sum(0));
            lat1[0] = $urandom_range(1, 6);
            lat1[1] = $urandom_range(1, 6);
            rand_args();
            start(1);
            finish(1, exp_lat(1), 0, ref_sum(1));
        end
        lat0 = '{4, 4};
        lat1 = '{3, 3};

        // Lane 1 two cycles late, plus spurious repeat/inactive strobes
        lat0 = '{4, 6};
        pulse = 1;
        cur[0:2] = '{7, 300, 1000000};
        start(0);
        finish(0, 13, 0, ref_sum(0));
        pulse = 0;
        lat0 = '{4, 4};

        // arg_vld held high with args changing mid-flight
        cur[0:2] = '{121, 144, 169};
        for (int i = 0; i < 5; i++) cur2[i] = $urandom;
        start(0);
        finish(0, 11, 1, 36);
        @(negedge clk);
        chk("hold_rdy_rise", rdy0, 1);
        chk("hold_rv_low", rv0, 0);
        @(posedge clk);
        finish(0, 11, 0, ref_sum(0));

        // Reset in the middle of WAIT
        cur[0:2] = '{1000, 2000, 3000};
        start(0);
        @(negedge clk);
        vld0 = 0;
        @(negedge clk);
        #2 rst = 1;
        #1;
        chk("midrst_rdy", rdy0, 0);
        chk("midrst_rv", rv0, 0);
        chk("midrst_xv", xv0, 0);
        chk("midrst_x", x0, 0);
        chk("midrst_res", res0, 0);
        last_res = '{0, 0};
        @(negedge clk);
        rst = 0;
        cur[0:2] = '{49, 64, 81};
        start(0);
        finish(0, 11, 0, 24);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
